// File: rtl/ucsbece154b_mem_arbiter_if.sv
// Cache-fill bus between the I/D caches, the memory arbiter and the SDRAM burst port.
// master is the arbiter's view; slave is the cache/SDRAM side.
interface ucsbece154b_mem_arbiter_if #(
    parameter int WORD_SIZE = 32
);
    logic                 IReadRequest;
    logic [31:0]          IReadAddress;
    logic [WORD_SIZE-1:0] IDataOut;
    logic                 IDataReady;
    logic                 IGrant;
    logic                 DReadRequest;
    logic [31:0]          DReadAddress;
    logic [WORD_SIZE-1:0] DDataOut;
    logic                 DDataReady;
    logic                 DGrant;
    logic [31:0]          MemReadAddress;
    logic                 MemReadRequest;
    logic [WORD_SIZE-1:0] MemDataIn;
    logic                 MemDataReady;

    modport master (
        input  IReadRequest, IReadAddress, DReadRequest, DReadAddress, MemDataIn, MemDataReady,
        output IDataOut, IDataReady, IGrant, DDataOut, DDataReady, DGrant,
               MemReadAddress, MemReadRequest
    );

    modport slave (
        output IReadRequest, IReadAddress, DReadRequest, DReadAddress, MemDataIn, MemDataReady,
        input  IDataOut, IDataReady, IGrant, DDataOut, DDataReady, DGrant,
               MemReadAddress, MemReadRequest
    );
endinterface

// File: rtl/ucsbece154b_mem_arbiter.sv
// Round-robin arbiter sharing one SDRAM burst port between I and D line fills; grant one cycle after a win.
// A burst runs BLOCK_WORDS beats paced by MemDataReady, then one DONE cycle; losers wait unacknowledged.
module ucsbece154b_mem_arbiter #(
    parameter int BLOCK_WORDS = 4,
    parameter int WORD_SIZE   = 32
) (
    input  logic Clk,
    input  logic Reset,
    ucsbece154b_mem_arbiter_if.master bus
);
    localparam int CW   = $clog2(BLOCK_WORDS);
    localparam int OFFS = CW + 2;
    localparam logic [CW-1:0] LAST_BEAT   = CW'(BLOCK_WORDS - 1);
    localparam logic [31:0]   OFFS_MASK   = (32'd1 << OFFS) - 32'd1;

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t        state;
    logic          owner;        // 0 = I, 1 = D
    logic          last_winner;  // 0 = I, 1 = D
    logic [CW-1:0] cnt;
    logic [31:0]   mem_addr;
    logic          mem_req;
    logic          i_grant;
    logic          d_grant;

    logic          win_d;
    logic [31:0]   win_addr;
    logic          i_route;
    logic          d_route;

    // On a tie the side that did not win last time gets the port.
    assign win_d    = bus.DReadRequest & (~bus.IReadRequest | ~last_winner);
    assign win_addr = win_d ? bus.DReadAddress : bus.IReadAddress;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_winner <= 1'b1;
            cnt         <= '0;
            mem_addr    <= '0;
            mem_req     <= 1'b0;
            i_grant     <= 1'b0;
            d_grant     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.IReadRequest || bus.DReadRequest) begin
                        state       <= BURST;
                        owner       <= win_d;
                        last_winner <= win_d;
                        cnt         <= '0;
                        mem_addr    <= win_addr & ~OFFS_MASK;
                        mem_req     <= 1'b1;
                        i_grant     <= ~win_d;
                        d_grant     <= win_d;
                    end
                end
                BURST: begin
                    if (bus.MemDataReady) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST_BEAT) begin
                            state   <= DONE;
                            mem_req <= 1'b0;
                            i_grant <= 1'b0;
                            d_grant <= 1'b0;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Beats are forwarded straight through so the owning cache sees data in the cycle it arrives.
    assign i_route = (state == BURST) && !owner;
    assign d_route = (state == BURST) && owner;

    assign bus.IDataReady     = i_route & bus.MemDataReady;
    assign bus.DDataReady     = d_route & bus.MemDataReady;
    assign bus.IDataOut       = i_route ? bus.MemDataIn : {WORD_SIZE{1'b0}};
    assign bus.DDataOut       = d_route ? bus.MemDataIn : {WORD_SIZE{1'b0}};
    assign bus.IGrant         = i_grant;
    assign bus.DGrant         = d_grant;
    assign bus.MemReadRequest = mem_req;
    assign bus.MemReadAddress = mem_addr;
endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Bench for the I/D memory arbiter: directed scenarios plus a long randomized run,
// all outputs compared every cycle against a transaction-level model.
module tb_ucsbece154b_mem_arbiter;
    localparam int BW = 4;
    localparam int WS = 32;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    ucsbece154b_mem_arbiter_if #(.WORD_SIZE(WS)) bus ();

    ucsbece154b_mem_arbiter #(.BLOCK_WORDS(BW), .WORD_SIZE(WS)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int ipulses = 0;
    int dpulses = 0;

    // Model: who holds the port, how many beats are still owed, and a one-cycle cool-down.
    bit          m_known = 0;
    bit          m_busy;
    bit          m_owner_d;
    bit          m_last_d;
    bit          m_cool;
    int          m_left;
    logic [31:0] m_addr;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        bit ig, dg;
        ig = m_busy && !m_owner_d;
        dg = m_busy && m_owner_d;
        chk("IGrant", 32'(bus.IGrant), 32'(ig));
        chk("DGrant", 32'(bus.DGrant), 32'(dg));
        chk("MemReadRequest", 32'(bus.MemReadRequest), 32'(m_busy));
        chk("MemReadAddress", bus.MemReadAddress, m_addr);
        chk("IDataReady", 32'(bus.IDataReady), 32'(ig && bus.MemDataReady));
        chk("DDataReady", 32'(bus.DDataReady), 32'(dg && bus.MemDataReady));
        chk("IDataOut", bus.IDataOut, ig ? bus.MemDataIn : 32'd0);
        chk("DDataOut", bus.DDataOut, dg ? bus.MemDataIn : 32'd0);
        if (bus.IDataReady === 1'b1) ipulses++;
        if (bus.DDataReady === 1'b1) dpulses++;
    endtask

    task automatic model_update();
        bit          wd;
        logic [31:0] a;
        if (Reset) begin
            m_known = 1; m_busy = 0; m_cool = 0; m_last_d = 1; m_owner_d = 0;
            m_left = 0; m_addr = 32'd0;
        end else if (!m_known) begin
            // nothing known before the first reset
        end else if (m_busy) begin
            if (bus.MemDataReady) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_cool = 1;
                end
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else if (bus.IReadRequest || bus.DReadRequest) begin
            if (bus.IReadRequest && bus.DReadRequest) wd = !m_last_d;
            else wd = bus.DReadRequest;
            a = wd ? bus.DReadAddress : bus.IReadAddress;
            m_addr    = a - (a % (BW * 4));
            m_busy    = 1;
            m_owner_d = wd;
            m_last_d  = wd;
            m_left    = BW;
        end
    endtask

    task automatic step();
        #1;
        if (m_known) compare();
        @(posedge Clk);
        model_update();
        @(negedge Clk);
    endtask

    task automatic beats(int n, int maxgap);
        for (int b = 0; b < n; b++) begin
            int g;
            g = int'($urandom_range(0, maxgap));
            for (int k = 0; k < g; k++) begin
                bus.MemDataReady = 1'b0;
                step();
            end
            bus.MemDataReady = 1'b1;
            bus.MemDataIn    = $urandom;
            step();
        end
        bus.MemDataReady = 1'b0;
    endtask

    initial begin
        int p0;
        Reset = 1'b1;
        bus.IReadRequest = 1'b0; bus.IReadAddress = 32'd0;
        bus.DReadRequest = 1'b0; bus.DReadAddress = 32'd0;
        bus.MemDataIn = 32'd0;   bus.MemDataReady = 1'b0;
        step();
        step();
        Reset = 1'b0;
        #1;
        chk("rst_igrant", 32'(bus.IGrant), 32'd0);
        chk("rst_dgrant", 32'(bus.DGrant), 32'd0);
        chk("rst_memreq", 32'(bus.MemReadRequest), 32'd0);
        chk("rst_addr", bus.MemReadAddress, 32'd0);

        // Single I fill with an unaligned address.
        bus.IReadRequest = 1'b1; bus.IReadAddress = 32'h0000_1234;
        step();
        bus.IReadRequest = 1'b0; bus.IReadAddress = 32'hFFFF_FFFF;
        #1;
        chk("fill_igrant", 32'(bus.IGrant), 32'd1);
        chk("fill_memreq", 32'(bus.MemReadRequest), 32'd1);
        chk("fill_addr", bus.MemReadAddress, 32'h0000_1230);
        chk("model_addr", m_addr, 32'h0000_1230);
        p0 = ipulses;
        beats(4, 0);
        chk("fill_pulses", 32'(ipulses - p0), 32'd4);
        bus.MemDataReady = 1'b1;
        #1;
        chk("done_memreq", 32'(bus.MemReadRequest), 32'd0);
        chk("done_irdy", 32'(bus.IDataReady), 32'd0);
        step();
        #1;
        chk("idle_irdy", 32'(bus.IDataReady), 32'd0);
        chk("idle_drdy", 32'(bus.DDataReady), 32'd0);
        step();
        bus.MemDataReady = 1'b0;

        // Ties alternate starting with I after reset.
        Reset = 1'b1; step(); Reset = 1'b0;
        bus.IReadRequest = 1'b1; bus.IReadAddress = 32'h0000_2000;
        bus.DReadRequest = 1'b1; bus.DReadAddress = 32'h0000_3004;
        step();
        #1;
        chk("tie1_igrant", 32'(bus.IGrant), 32'd1);
        chk("tie1_dgrant", 32'(bus.DGrant), 32'd0);
        beats(4, 0);
        step();
        step();
        #1;
        chk("tie2_dgrant", 32'(bus.DGrant), 32'd1);
        chk("tie2_addr", bus.MemReadAddress, 32'h0000_3000);
        beats(4, 0);
        step();
        step();
        #1;
        chk("tie3_igrant", 32'(bus.IGrant), 32'd1);
        bus.IReadRequest = 1'b0; bus.DReadRequest = 1'b0;
        beats(4, 1);
        step();

        // Gapped beats: the burst must end exactly after the fourth.
        bus.IReadRequest = 1'b1; bus.IReadAddress = $urandom;
        step();
        bus.IReadRequest = 1'b0;
        p0 = ipulses;
        beats(4, 3);
        chk("gap_pulses", 32'(ipulses - p0), 32'd4);
        #1;
        chk("gap_done", 32'(bus.MemReadRequest), 32'd0);
        step();

        // Reset after two beats abandons the burst; the next burst counts from zero.
        bus.IReadRequest = 1'b1; bus.IReadAddress = 32'h0000_5550;
        step();
        bus.IReadRequest = 1'b0;
        beats(2, 1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        #1;
        chk("rstmid_memreq", 32'(bus.MemReadRequest), 32'd0);
        chk("rstmid_igrant", 32'(bus.IGrant), 32'd0);
        bus.MemDataReady = 1'b1;
        #1;
        chk("rstmid_irdy", 32'(bus.IDataReady), 32'd0);
        step();
        bus.MemDataReady = 1'b0;
        bus.IReadRequest = 1'b1; bus.IReadAddress = 32'h0000_ABCF;
        step();
        bus.IReadRequest = 1'b0;
        #1;
        chk("restart_addr", bus.MemReadAddress, 32'h0000_ABC0);
        p0 = ipulses;
        beats(4, 0);
        chk("restart_pulses", 32'(ipulses - p0), 32'd4);
        #1;
        chk("restart_done", 32'(bus.MemReadRequest), 32'd0);
        step();

        // D request dropped right after winning still gets a full line.
        bus.DReadRequest = 1'b1; bus.DReadAddress = 32'h1000_0008;
        step();
        bus.DReadRequest = 1'b0;
        p0 = dpulses;
        beats(4, 2);
        chk("drop_pulses", 32'(dpulses - p0), 32'd4);
        step();

        for (int c = 0; c < 4000; c++) begin
            Reset = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 4) == 0) bus.IReadRequest = ~bus.IReadRequest;
            if ($urandom_range(0, 4) == 0) bus.DReadRequest = ~bus.DReadRequest;
            bus.IReadAddress = $urandom;
            bus.DReadAddress = $urandom;
            bus.MemDataReady = ($urandom_range(0, 1) == 1);
            bus.MemDataIn    = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
